dmem_arbiter: RTL and testbench

//  Shares the single data-memory port between the CPU load/store path and a debug/loader requester.

---
 rtl/dmem_arbiter_pkg.sv | 21 ++
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_arbiter_pick.sv | 36 +++
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 tb/tb_dmem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester ids, width helper.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef enum logic {
    ID_CPU = 1'b0,
    ID_DBG = 1'b1
  } req_id_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: CPU and debug requester handshakes, memory port, status.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_stall;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_ack;

  logic          mem_re;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          proto_err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    output dbg_rdata, dbg_ack,
    output mem_re, mem_we, mem_addr, mem_wdata,
    output busy, proto_err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    input  dbg_rdata, dbg_ack,
    input  mem_re, mem_we, mem_addr, mem_wdata,
    input  busy, proto_err
  );
endinterface

// File: rtl/dmem_arbiter_pick.sv
// Winner select for the two requesters plus the debug starvation counter.
module dmem_arbiter_pick
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    cpu_req,
  input  logic    dbg_req,
  input  logic    grant,
  output req_id_e winner
);
  localparam int SW = cnt_w(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == SW'(STARVE_MAX));

  // CPU wins ties unless debug has already lost STARVE_MAX times in a row.
  always_comb begin
    winner = ID_CPU;
    if (dbg_req && (!cpu_req || starved)) winner = ID_DBG;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (winner == ID_DBG)        starve_cnt <= '0;
      else if (dbg_req && !starved) starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU and a debug/loader requester.
// Define DMEM_ARB_PROTO_CHECK_EN to build the sticky handshake-violation checker (proto_err).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  localparam int LW = cnt_w(MEM_LAT);

  state_e        state, state_nxt;
  logic [LW-1:0] lat_cnt;
  logic          grant;
  logic          last_wait;
  logic          sample;
  req_id_e       winner;
  req_id_e       id_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] dbg_rdata_q;

  dmem_arbiter_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk     (clk),
    .reset   (reset),
    .cpu_req (bus.cpu_req),
    .dbg_req (bus.dbg_req),
    .grant   (grant),
    .winner  (winner)
  );

  assign last_wait = (state == ST_WAIT) && (lat_cnt == LW'(MEM_LAT - 2));
  // Read data is valid in the last cycle before DONE: ACCESS itself for an async-read memory.
  assign sample    = !we_q && ((MEM_LAT == 1) ? (state == ST_ACCESS) : last_wait);

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.cpu_req || bus.dbg_req) begin
          grant     = 1'b1;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: state_nxt = (MEM_LAT == 1) ? ST_DONE : ST_WAIT;
      ST_WAIT:   if (last_wait) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 lat_cnt <= '0;
    else if (state == ST_WAIT)  lat_cnt <= lat_cnt + 1'b1;
    else                        lat_cnt <= '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_q    <= ID_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      id_q <= winner;
      if (winner == ID_DBG) begin
        we_q    <= bus.dbg_we;
        addr_q  <= bus.dbg_addr;
        wdata_q <= bus.dbg_wdata;
      end else begin
        we_q    <= bus.cpu_we;
        addr_q  <= bus.cpu_addr;
        wdata_q <= bus.cpu_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else if (sample) begin
      if (id_q == ID_CPU) cpu_rdata_q <= bus.mem_rdata;
      else                dbg_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.mem_re    = (state == ST_ACCESS) && !we_q;
  assign bus.mem_we    = (state == ST_ACCESS) &&  we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.cpu_ack   = (state == ST_DONE) && (id_q == ID_CPU);
  assign bus.dbg_ack   = (state == ST_DONE) && (id_q == ID_DBG);
  assign bus.cpu_stall = bus.cpu_req && !bus.cpu_ack;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;

`ifdef DMEM_ARB_PROTO_CHECK_EN
  logic viol;
  logic proto_q;

  // Granted requester must hold req and all fields from grant through its ack cycle.
  always_comb begin
    viol = 1'b0;
    if (state != ST_IDLE) begin
      if (id_q == ID_CPU)
        viol = !bus.cpu_req || (bus.cpu_we != we_q) ||
               (bus.cpu_addr != addr_q) || (bus.cpu_wdata != wdata_q);
      else
        viol = !bus.dbg_req || (bus.dbg_we != we_q) ||
               (bus.dbg_addr != addr_q) || (bus.dbg_wdata != wdata_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) proto_q <= 1'b0;
    else        proto_q <= proto_q | viol;
  end

  assign bus.proto_err = proto_q;
`else
  assign bus.proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed cases on a MEM_LAT=1 instance, random traffic on a MEM_LAT=3
// instance checked every cycle against a transaction-level model (grant cycle + fixed offsets).
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 3;
  localparam int SMAX = 4;
`ifdef DMEM_ARB_PROTO_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) b3 ();
  dmem_arbiter_if #(.AW(AW), .DW(DW)) b1 ();

  dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut3 (
    .clk(clk), .reset(reset), .bus(b3));
  dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_MAX(SMAX)) dut1 (
    .clk(clk), .reset(reset), .bus(b1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : (32'hA500_0000 | 32'(i * 257));
  endfunction

  // Memories: b1 side is async-read, b3 side presents data only in cycle strobe+LAT-1.
  logic        mem_init = 1'b0;
  logic [31:0] mem1 [0:63];
  logic [31:0] mem3 [0:63];
  logic        rd_v0, rd_v1;
  logic [5:0]  rd_a0, rd_a1;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) begin
        mem1[i] <= init_val(i);
        mem3[i] <= init_val(i);
      end
    end else begin
      if (b1.mem_we) mem1[b1.mem_addr[7:2]] <= b1.mem_wdata;
      if (b3.mem_we) mem3[b3.mem_addr[7:2]] <= b3.mem_wdata;
    end
    rd_v0 <= b3.mem_re;
    rd_a0 <= b3.mem_addr[7:2];
    rd_v1 <= rd_v0;
    rd_a1 <= rd_a0;
  end

  assign b1.mem_rdata = mem1[b1.mem_addr[7:2]];
  assign b3.mem_rdata = rd_v1 ? mem3[rd_a1] : 32'hBAD0_BAD0;

  // Model state: one outstanding access described by its grant cycle and latched fields.
  int          cyc = 0;
  int          gcyc = 0;
  bit          mb, mwho, mwe, mperr;
  int          mst;
  logic [31:0] maddr, mwdata, mq_addr, mq_wdata, mcpu_rd, mdbg_rd;
  logic [31:0] mmem [0:63];
  bit          last_cpu_ack, last_dbg_ack;
  int          ack_log[$];

  always @(negedge clk) begin
    int k;
    bit eack_c, eack_d, viol, dwin;
    cyc++;
    last_cpu_ack = b3.cpu_ack;
    last_dbg_ack = b3.dbg_ack;
    if (b3.cpu_ack) ack_log.push_back(0);
    if (b3.dbg_ack) ack_log.push_back(1);
    if (!reset) begin
      mb = 0; mst = 0; mperr = 0;
      mcpu_rd = '0; mdbg_rd = '0; mq_addr = '0; mq_wdata = '0;
      chk("rst_busy", b3.busy, 0);
      chk("rst_mem_re", b3.mem_re, 0);
      chk("rst_mem_we", b3.mem_we, 0);
      chk("rst_mem_addr", b3.mem_addr, 0);
      chk("rst_mem_wdata", b3.mem_wdata, 0);
      chk("rst_cpu_ack", b3.cpu_ack, 0);
      chk("rst_dbg_ack", b3.dbg_ack, 0);
      chk("rst_cpu_rdata", b3.cpu_rdata, 0);
      chk("rst_dbg_rdata", b3.dbg_rdata, 0);
      chk("rst_proto", b3.proto_err, 0);
      chk("rst_stall", b3.cpu_stall, b3.cpu_req);
    end else begin
      k      = cyc - gcyc;
      eack_c = mb && (k == LAT + 1) && !mwho;
      eack_d = mb && (k == LAT + 1) &&  mwho;
      if (mb && k == 1 && mwe) mmem[maddr[7:2]] = mwdata;
      if (mb && k == LAT + 1 && !mwe) begin
        if (mwho) mdbg_rd = mmem[maddr[7:2]];
        else      mcpu_rd = mmem[maddr[7:2]];
      end
      chk("busy", b3.busy, mb);
      chk("mem_re", b3.mem_re, mb && k == 1 && !mwe);
      chk("mem_we", b3.mem_we, mb && k == 1 && mwe);
      chk("mem_addr", b3.mem_addr, mq_addr);
      chk("mem_wdata", b3.mem_wdata, mq_wdata);
      chk("cpu_ack", b3.cpu_ack, eack_c);
      chk("dbg_ack", b3.dbg_ack, eack_d);
      chk("cpu_rdata", b3.cpu_rdata, mcpu_rd);
      chk("dbg_rdata", b3.dbg_rdata, mdbg_rd);
      chk("cpu_stall", b3.cpu_stall, b3.cpu_req && !eack_c);
      chk("proto_err", b3.proto_err, mperr);
      if (PCHK && mb) begin
        if (mwho) viol = !b3.dbg_req || b3.dbg_we !== mwe || b3.dbg_addr !== maddr || b3.dbg_wdata !== mwdata;
        else      viol = !b3.cpu_req || b3.cpu_we !== mwe || b3.cpu_addr !== maddr || b3.cpu_wdata !== mwdata;
        if (viol) mperr = 1;
      end
      if (eack_c || eack_d) begin
        mb = 0;
      end else if (!mb && (b3.cpu_req || b3.dbg_req)) begin
        dwin = b3.dbg_req && (!b3.cpu_req || mst == SMAX);
        if (dwin) mst = 0;
        else if (b3.dbg_req && mst < SMAX) mst++;
        mwho   = dwin;
        mwe    = dwin ? b3.dbg_we    : b3.cpu_we;
        maddr  = dwin ? b3.dbg_addr  : b3.cpu_addr;
        mwdata = dwin ? b3.dbg_wdata : b3.cpu_wdata;
        mq_addr  = maddr;
        mq_wdata = mwdata;
        gcyc = cyc;
        mb   = 1;
      end
    end
  end

  // Stimulus
  bit cpu_pend, dbg_pend;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    b3.cpu_req = 0; b3.cpu_we = 0; b3.cpu_addr = '0; b3.cpu_wdata = '0;
    b3.dbg_req = 0; b3.dbg_we = 0; b3.dbg_addr = '0; b3.dbg_wdata = '0;
    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
    b1.dbg_req = 0; b1.dbg_we = 0; b1.dbg_addr = '0; b1.dbg_wdata = '0;
    cpu_pend = 0; dbg_pend = 0;
  endtask

  task automatic do_reset();
    idle_all();
    repeat (LAT + 3) tick();
    reset = 0;
    tick(); tick();
    reset = 1;
    tick();
  endtask

  // Requesters hold a request until they have seen its ack, then maybe issue another at once.
  task automatic agent_step(input int pc, input int pd);
    if (!cpu_pend || last_cpu_ack) begin
      cpu_pend = 0;
      if (int'($urandom_range(99)) < pc) begin
        cpu_pend = 1; b3.cpu_req = 1;
        b3.cpu_we = 1'($urandom_range(1));
        b3.cpu_addr = 32'($urandom_range(63)) << 2;
        b3.cpu_wdata = $urandom;
      end else b3.cpu_req = 0;
    end
    if (!dbg_pend || last_dbg_ack) begin
      dbg_pend = 0;
      if (int'($urandom_range(99)) < pd) begin
        dbg_pend = 1; b3.dbg_req = 1;
        b3.dbg_we = 1'($urandom_range(1));
        b3.dbg_addr = 32'($urandom_range(63)) << 2;
        b3.dbg_wdata = $urandom;
      end else b3.dbg_req = 0;
    end
  endtask

  initial begin
    int nwe, nack;
    bit got;
    int exp_order [10];
    for (int i = 0; i < 64; i++) mmem[i] = init_val(i);

    // 1: reset held with random inputs
    mem_init = 1;
    for (int i = 0; i < 4; i++) begin
      b3.cpu_req = 1'($urandom_range(1)); b3.cpu_we = 1'($urandom_range(1));
      b3.cpu_addr = $urandom; b3.cpu_wdata = $urandom;
      b3.dbg_req = 1'($urandom_range(1)); b3.dbg_we = 1'($urandom_range(1));
      b3.dbg_addr = $urandom; b3.dbg_wdata = $urandom;
      b1.cpu_req = 1'($urandom_range(1)); b1.cpu_we = 1'($urandom_range(1));
      b1.cpu_addr = $urandom; b1.cpu_wdata = $urandom;
      b1.dbg_req = 1'($urandom_range(1)); b1.dbg_we = 1'($urandom_range(1));
      b1.dbg_addr = $urandom; b1.dbg_wdata = $urandom;
      tick();
      chk("t1_busy", b1.busy, 0);
      chk("t1_strobes", {b1.mem_re, b1.mem_we}, 0);
      chk("t1_acks", {b1.cpu_ack, b1.dbg_ack}, 0);
      chk("t1_mem_addr", b1.mem_addr, 0);
      chk("t1_proto", b1.proto_err, 0);
    end
    mem_init = 0;
    idle_all();
    reset = 1;
    tick(); tick();
    chk("t1_rel_busy", b1.busy, 0);
    chk("t1_rel_ack", b1.cpu_ack, 0);

    // 2: MEM_LAT=1 CPU load of 0x10
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 32'h10;
    #1;
    chk("t2_stall_c0", b1.cpu_stall, 1);
    chk("t2_re_c0", b1.mem_re, 0);
    tick();
    chk("t2_re_c1", b1.mem_re, 1);
    chk("t2_addr_c1", b1.mem_addr, 32'h10);
    chk("t2_stall_c1", b1.cpu_stall, 1);
    chk("t2_ack_c1", b1.cpu_ack, 0);
    tick();
    chk("t2_ack_c2", b1.cpu_ack, 1);
    chk("t2_rdata_c2", b1.cpu_rdata, 32'hDEAD_BEEF);
    chk("t2_stall_c2", b1.cpu_stall, 0);
    tick();
    b1.cpu_req = 0;
    #1;
    chk("t2_idle_c3", b1.busy, 0);

    // 3: debug store then CPU load of the same word
    b1.dbg_req = 1; b1.dbg_we = 1; b1.dbg_addr = 32'h20; b1.dbg_wdata = 32'h1234_5678;
    nwe = 0; nack = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      nwe  += int'(b1.mem_we);
      nack += int'(b1.dbg_ack);
    end
    tick();
    b1.dbg_req = 0;
    #1;
    nwe += int'(b1.mem_we);
    for (int i = 0; i < 2; i++) begin
      tick();
      nwe += int'(b1.mem_we);
    end
    chk("t3_we_cycles", nwe, 1);
    chk("t3_dbg_acks", nack, 1);
    chk("t3_dbg_rdata_kept", b1.dbg_rdata, 0);
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 32'h20;
    tick(); tick();
    chk("t3_cpu_ack", b1.cpu_ack, 1);
    chk("t3_cpu_rdata", b1.cpu_rdata, 32'h1234_5678);
    tick();
    b1.cpu_req = 0;

    // 4: both requesters continuously busy
    do_reset();
    ack_log.delete();
    repeat (12 * (LAT + 2)) begin
      agent_step(100, 100);
      tick();
    end
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    chk("t4_nacks", ack_log.size() >= 10, 1);
    for (int i = 0; i < 10 && i < ack_log.size(); i++)
      chk($sformatf("t4_order%0d", i), ack_log[i], exp_order[i]);

    // Random traffic
    do_reset();
    repeat (800) begin agent_step(35, 35); tick(); end
    repeat (300) begin agent_step(90, 90); tick(); end
    repeat (200) begin agent_step(10, 80); tick(); end

    // 5: reset during WAIT of a CPU load
    do_reset();
    b3.cpu_req = 1; b3.cpu_we = 0; b3.cpu_addr = 32'h10;
    tick(); tick();
    chk("t5_busy_wait", b3.busy, 1);
    reset = 0;
    b3.cpu_req = 0;
    #1;
    chk("t5_busy_drop", b3.busy, 0);
    chk("t5_re_drop", b3.mem_re, 0);
    tick(); tick();
    reset = 1;
    nack = 0;
    repeat (10) begin
      tick();
      nack += int'(b3.cpu_ack);
    end
    chk("t5_no_ack", nack, 0);

    // 6: CPU changes its address during WAIT
    do_reset();
    b3.cpu_req = 1; b3.cpu_we = 0; b3.cpu_addr = 32'h10;
    tick();
    chk("t6_re", b3.mem_re, 1);
    chk("t6_addr", b3.mem_addr, 32'h10);
    tick();
    b3.cpu_addr = 32'h14;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (b3.cpu_ack) got = 1;
    end
    chk("t6_ack", got, 1);
    chk("t6_rdata", b3.cpu_rdata, mmem[4]);
    tick();
    b3.cpu_req = 0;
    repeat (3) tick();
    chk("t6_proto", b3.proto_err, PCHK);
    do_reset();
    chk("t6_proto_clr", b3.proto_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
